// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared FSM state type and keep-to-BE encoding for eth_tx_arbiter_rr
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam int MAX_KEEP_W = 8;

  // Byte count of a keep mask; the caller truncates to BE width so a full beat encodes as 0.
  function automatic logic [3:0] keep_to_be(input logic [MAX_KEEP_W-1:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// rtl/eth_tx_arbiter_rr_pick.sv - rr_pick: combinational round-robin winner search from ptr+1 upward
module rr_pick #(
  parameter int NUM_CH = 3,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              found
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!found && req[c] && (((int'(ptr) + k) % NUM_CH) == c)) begin
          gnt[c] = 1'b1;
          idx    = PTR_W'(c);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter_rr.sv
// rtl/eth_tx_arbiter_rr.sv - packet-atomic round-robin TX arbiter onto MAC write port; watchdog via ARB_WDOG_EN
module eth_tx_arbiter_rr
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int BE_W    = $clog2(KEEP_W),
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_user_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        tx_req_i,
  output logic [NUM_CH-1:0]        tx_gnt_o,
  input  logic [NUM_CH-1:0]        tx_vld_i,
  input  logic [NUM_CH*DATA_W-1:0] tx_data_i,
  input  logic [NUM_CH*KEEP_W-1:0] tx_keep_i,
  input  logic [NUM_CH-1:0]        tx_last_i,
  output logic [NUM_CH-1:0]        tx_rdy_o,
  input  logic                     Tx_mac_wa,
  output logic                     Tx_mac_wr,
  output logic [DATA_W-1:0]        Tx_mac_data,
  output logic [BE_W-1:0]          Tx_mac_BE,
  output logic                     Tx_mac_sop,
  output logic                     Tx_mac_eop,
  output logic                     wdog_abort_o
);

  localparam int PTR_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT < 1 || KEEP_W > MAX_KEEP_W) begin : g_bad_params
    $error("eth_tx_arbiter_rr: unsupported parameter set");
  end

  state_t                state, state_nx;
  logic [PTR_W-1:0]      ptr;
  logic [NUM_CH-1:0]     pick;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [DATA_W-1:0]     sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  sel_last;
  logic [MAX_KEEP_W-1:0] keep_ext;
  logic [BE_W-1:0]       eop_be;
  logic                  first_beat;
  logic                  accept;
  logic                  abort;

  rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick (
    .req   (tx_req_i),
    .ptr   (ptr),
    .gnt   (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tx_gnt_o[c]) begin
        sel_data = tx_data_i[c*DATA_W +: DATA_W];
        sel_keep = tx_keep_i[c*KEEP_W +: KEEP_W];
        sel_last = tx_last_i[c];
      end
    end
  end

  assign keep_ext = MAX_KEEP_W'(sel_keep);
  assign eop_be   = BE_W'(keep_to_be(keep_ext));

  // Reset gates ready so a source never believes a beat was taken during the reset cycle.
  assign tx_rdy_o = (state == XFER && Tx_mac_wa && !reset_i) ? tx_gnt_o : '0;
  assign accept   = |(tx_vld_i & tx_rdy_o);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_found) state_nx = GRANT;
      GRANT:   state_nx = XFER;
      XFER:    if ((accept && sel_last) || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      state       <= IDLE;
      ptr         <= PTR_W'(NUM_CH - 1);
      tx_gnt_o    <= '0;
      first_beat  <= 1'b0;
      Tx_mac_wr   <= 1'b0;
      Tx_mac_data <= '0;
      Tx_mac_BE   <= '0;
      Tx_mac_sop  <= 1'b0;
      Tx_mac_eop  <= 1'b0;
    end else begin
      state      <= state_nx;
      Tx_mac_wr  <= accept || abort;
      Tx_mac_sop <= 1'b0;
      Tx_mac_eop <= 1'b0;
      Tx_mac_BE  <= '0;
      if (state == IDLE && pick_found) begin
        tx_gnt_o   <= pick;
        ptr        <= pick_idx;
        first_beat <= 1'b1;
      end
      if (state == XFER && ((accept && sel_last) || abort)) begin
        tx_gnt_o <= '0;
      end
      if (accept) begin
        Tx_mac_data <= sel_data;
        Tx_mac_sop  <= first_beat;
        Tx_mac_eop  <= sel_last;
        Tx_mac_BE   <= sel_last ? eop_be : '0;
        first_beat  <= 1'b0;
      end else if (abort) begin
        // Forced terminator so the MAC closes the frame it already started.
        Tx_mac_data <= '0;
        Tx_mac_sop  <= first_beat;
        Tx_mac_eop  <= 1'b1;
        Tx_mac_BE   <= BE_W'(1);
        first_beat  <= 1'b0;
      end
    end
  end

`ifdef ARB_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  assign stalled = (state == XFER) && Tx_mac_wa && !accept;
  assign abort   = stalled && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      stall_cnt    <= '0;
      wdog_abort_o <= 1'b0;
    end else begin
      wdog_abort_o <= abort;
      if (state != XFER || accept || abort) begin
        stall_cnt <= '0;
      end else if (stalled) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign abort        = 1'b0;
  assign wdog_abort_o = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter_rr.sv
// tb/tb_eth_tx_arbiter_rr.sv - scoreboard bench for eth_tx_arbiter_rr with a packet-level round-robin model
module tb_eth_tx_arbiter_rr;

  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 32;
  localparam int KEEP_W  = 4;
  localparam int BE_W    = 2;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        tx_req, tx_gnt, tx_vld, tx_last, tx_rdy;
  logic [NUM_CH*DATA_W-1:0] tx_data;
  logic [NUM_CH*KEEP_W-1:0] tx_keep;
  logic                     wa, mac_wr, mac_sop, mac_eop, wdog;
  logic [DATA_W-1:0]        mac_data;
  logic [BE_W-1:0]          mac_be;

  always #5 clk = ~clk;

  eth_tx_arbiter_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .BE_W(BE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_user_i(clk), .reset_i(rst), .tx_req_i(tx_req), .tx_gnt_o(tx_gnt), .tx_vld_i(tx_vld),
    .tx_data_i(tx_data), .tx_keep_i(tx_keep), .tx_last_i(tx_last), .tx_rdy_o(tx_rdy),
    .Tx_mac_wa(wa), .Tx_mac_wr(mac_wr), .Tx_mac_data(mac_data), .Tx_mac_BE(mac_be),
    .Tx_mac_sop(mac_sop), .Tx_mac_eop(mac_eop), .wdog_abort_o(wdog)
  );

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; logic stall; } src_beat_t;
  typedef struct { logic [31:0] data; logic sop; logic eop; logic [1:0] be; logic abort; int gap; } exp_beat_t;

  src_beat_t src_q[NUM_CH][$];
  exp_beat_t exp_q[$];
  int        gnt_q[$];

  int total = 0, bad = 0;
  int mptr;
  int vld_pct, wa_pct;
  bit junk_en;
  int idle_run[NUM_CH];
  bit chk_zero = 0, chk_end = 0, tmo_flag = 0;

  // Packet-level model: queues source beats and the beats/grant the MAC side must show.
  task automatic add_pkt(input int c, input int len, input int nbytes, input bit stall_first);
    src_beat_t s;
    exp_beat_t e;
    gnt_q.push_back(1 << c);
    mptr = c;
    for (int b = 0; b < len; b++) begin
      s.data  = $urandom;
      s.last  = (b == len - 1);
      s.keep  = s.last ? 4'((1 << nbytes) - 1) : 4'($urandom);
      s.stall = stall_first && (b == 0);
      src_q[c].push_back(s);
      e.data = s.data; e.sop = (b == 0); e.eop = s.last;
      e.be = s.last ? 2'(nbytes % 4) : 2'd0; e.abort = 1'b0; e.gap = 0;
      if (!stall_first || b == 0) exp_q.push_back(e);
    end
    if (stall_first) begin
      e.data = '0; e.sop = 1'b0; e.eop = 1'b1; e.be = 2'd1; e.abort = 1'b1; e.gap = TIMEOUT;
      exp_q.push_back(e);
    end
  endtask

  // Every channel with packets left stays backlogged, so winners rotate upward from the last winner.
  task automatic plan(input int n[NUM_CH], input int len_max);
    int left[NUM_CH];
    int remaining;
    bit done;
    remaining = 0;
    for (int c = 0; c < NUM_CH; c++) begin left[c] = n[c]; remaining += n[c]; end
    while (remaining > 0) begin
      done = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (mptr + k) % NUM_CH;
        if (!done && left[c] > 0) begin
          add_pkt(c, $urandom_range(1, len_max), $urandom_range(1, 4), 1'b0);
          left[c]--; remaining--; done = 1;
        end
      end
    end
  endtask

  task automatic update_drive();
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0) begin
        tx_req[c] = 1'b1;
        tx_data[c*DATA_W +: DATA_W] = src_q[c][0].data;
        tx_keep[c*KEEP_W +: KEEP_W] = src_q[c][0].keep;
        tx_last[c] = src_q[c][0].last;
        tx_vld[c] = (idle_run[c] >= 3) || ($urandom_range(0, 99) < vld_pct);
      end else begin
        tx_req[c] = 1'b0;
        tx_vld[c] = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_data[c*DATA_W +: DATA_W] = $urandom;
        tx_keep[c*KEEP_W +: KEEP_W] = 4'($urandom);
        tx_last[c] = 1'($urandom);
      end
      idle_run[c] = tx_vld[c] ? 0 : idle_run[c] + 1;
    end
    wa = ($urandom_range(0, 99) < wa_pct);
  endtask

  task automatic run_traffic(input int stop_hs, input int max_cyc);
    bit hs[NUM_CH];
    int hs_cnt, cycles;
    bit empty;
    hs_cnt = 0; cycles = 0;
    while (1) begin
      update_drive();
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) hs[c] = tx_vld[c] & tx_rdy[c];
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[c] && src_q[c].size() > 0) begin
          hs_cnt++;
          if (src_q[c][0].stall) src_q[c].delete();
          else void'(src_q[c].pop_front());
        end
      end
      cycles++;
      empty = (exp_q.size() == 0);
      for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) empty = 0;
      if (stop_hs > 0 && hs_cnt >= stop_hs) break;
      if (max_cyc > 0 && cycles >= max_cyc) break;
      if (stop_hs == 0 && max_cyc == 0 && empty) break;
      if (cycles > 5000) begin
        tmo_flag = 1; @(posedge clk); #1; tmo_flag = 0;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1; tx_req = '0; tx_vld = '0;
    for (int c = 0; c < NUM_CH; c++) begin src_q[c].delete(); idle_run[c] = 0; end
    @(posedge clk); #1;
    exp_q.delete(); gnt_q.delete();
    chk_zero = 1; rst = 0; mptr = NUM_CH - 1;
    @(posedge clk); #1;
    chk_zero = 0;
  endtask

  exp_beat_t mon_e;
  int cyc = 0, last_eop_cyc = -100, last_wr_cyc = -100;
  logic [NUM_CH-1:0] prev_gnt = '0;
  logic prev_wa = 1'b1;
  int g_exp;

  always @(negedge clk) begin
    cyc++;
    if (mac_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got data=%h sop=%0d eop=%0d be=%0d want none", mac_data, mac_sop, mac_eop, mac_be);
      end else begin
        mon_e = exp_q.pop_front();
        if (mac_data !== mon_e.data || mac_sop !== mon_e.sop || mac_eop !== mon_e.eop ||
            mac_be !== mon_e.be || wdog !== mon_e.abort) begin
          bad++;
          $display("FAIL beat got data=%h sop=%0d eop=%0d be=%0d abort=%0d want data=%h sop=%0d eop=%0d be=%0d abort=%0d",
                   mac_data, mac_sop, mac_eop, mac_be, wdog, mon_e.data, mon_e.sop, mon_e.eop, mon_e.be, mon_e.abort);
        end
        if (mon_e.gap != 0) begin
          total++;
          if (cyc - last_wr_cyc != mon_e.gap) begin
            bad++;
            $display("FAIL wdog_delay got %0d want %0d", cyc - last_wr_cyc, mon_e.gap);
          end
        end
      end
      if (mac_sop) begin
        total++;
        if (cyc - last_eop_cyc < 3) begin
          bad++;
          $display("FAIL pkt_gap got %0d idle want >=2", cyc - last_eop_cyc - 1);
        end
      end
      if (mac_eop) last_eop_cyc = cyc;
      last_wr_cyc = cyc;
    end else if (wdog) begin
      total++; bad++;
      $display("FAIL abort_without_beat got wdog=1 want 0");
    end
    if (!wa) begin
      total++;
      if (tx_rdy !== '0) begin bad++; $display("FAIL rdy_wa_low got %b want 0", tx_rdy); end
    end
    if (!prev_wa) begin
      total++;
      if (mac_wr !== 1'b0) begin bad++; $display("FAIL wr_after_wa_low got %b want 0", mac_wr); end
    end
    total++;
    if (!$onehot0(tx_gnt) || (tx_rdy & ~tx_gnt) !== '0) begin
      bad++;
      $display("FAIL gnt_rdy_shape got gnt=%b rdy=%b want onehot0 gnt and rdy within gnt", tx_gnt, tx_rdy);
    end
    if (prev_gnt == '0 && tx_gnt != '0) begin
      total++;
      g_exp = (gnt_q.size() > 0) ? gnt_q.pop_front() : 0;
      if (int'(tx_gnt) != g_exp) begin bad++; $display("FAIL grant_order got %b want %b", tx_gnt, g_exp[NUM_CH-1:0]); end
    end
    if (chk_zero) begin
      total++;
      if ({tx_gnt, tx_rdy, mac_wr, mac_sop, mac_eop, mac_data, mac_be, wdog} !== '0) begin
        bad++;
        $display("FAIL reset_state got gnt=%b rdy=%b wr=%b sop=%b eop=%b data=%h be=%0d wdog=%b want all 0",
                 tx_gnt, tx_rdy, mac_wr, mac_sop, mac_eop, mac_data, mac_be, wdog);
      end
    end
    if (chk_end) begin
      total++;
      if (exp_q.size() != 0 || gnt_q.size() != 0) begin
        bad++;
        $display("FAIL leftover got beats=%0d grants=%0d want 0 0", exp_q.size(), gnt_q.size());
      end
    end
    if (tmo_flag) begin
      total++; bad++;
      $display("FAIL traffic_timeout got pending beats=%0d want drained", exp_q.size());
    end
    prev_gnt = tx_gnt;
    prev_wa  = wa;
  end

  int cnt[NUM_CH];

  initial begin
    rst = 1; tx_req = '0; tx_vld = '0; tx_last = '0; tx_data = '0; tx_keep = '0; wa = 1'b1;
    vld_pct = 100; wa_pct = 100; junk_en = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    add_pkt(1, 3, 4, 1'b0);
    run_traffic(0, 0);

    reset_dut();
    cnt = '{2, 1, 1};
    plan(cnt, 4);
    run_traffic(0, 0);

    add_pkt(2, 1, 3, 1'b0);
    add_pkt(2, 1, 1, 1'b0);
    run_traffic(0, 0);

    add_pkt(0, 6, 2, 1'b0);
    run_traffic(2, 0);
    wa_pct = 0;
    run_traffic(0, 5);
    wa_pct = 100;
    run_traffic(0, 0);

    add_pkt(1, 6, 4, 1'b0);
    run_traffic(2, 0);
    reset_dut();
    cnt = '{1, 1, 0};
    plan(cnt, 3);
    run_traffic(0, 0);

`ifdef ARB_WDOG_EN
    reset_dut();
    add_pkt(0, 2, 4, 1'b0);
    add_pkt(2, 3, 4, 1'b1);
    add_pkt(0, 2, 2, 1'b0);
    run_traffic(0, 0);
`endif

    for (int ph = 0; ph < 3; ph++) begin
      reset_dut();
      vld_pct = 70; wa_pct = 75; junk_en = 1;
      for (int c = 0; c < NUM_CH; c++) cnt[c] = $urandom_range(0, 5);
      plan(cnt, 6);
      run_traffic(0, 0);
      junk_en = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk_end = 1;
    @(posedge clk); #1;
    chk_end = 0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
